// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int S_ADDR_W    = 8;
  localparam int S_DATA_W    = 8;
  localparam int S_DEPTH     = 256;
  localparam int KEY_LEN_DEF = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_I,
    ST_WAIT_I,
    ST_CAP_I,
    ST_READ_J,
    ST_WAIT_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_DONE
  } ksa_state_t;

  // Width of a 0..n-1 index, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Picks key byte kidx out of the packed key; byte 0 is the most significant byte.
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int KI_W    = idx_w(KEY_LEN)
) (
  input  logic [8*KEY_LEN-1:0] i_key,
  input  logic [KI_W-1:0]      i_kidx,
  output logic [7:0]           o_byte
);

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (i_kidx == KI_W'(k)) o_byte = i_key[8*(KEY_LEN-1-k) +: 8];
    end
  end

endmodule

// File: rtl/ksa_scramble.sv
// RC4 key-scheduling pass over a 256x8 S-array RAM with configurable read latency.
module ksa_scramble
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int RD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_scramble,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [S_DATA_W-1:0]  ram_q,
  output logic [S_ADDR_W-1:0]  ram_address_scramble,
  output logic [S_DATA_W-1:0]  ram_data_scramble,
  output logic                 ram_wren_scramble,
  output logic                 done_scrambling
);

  localparam int KI_W = idx_w(KEY_LEN);
  localparam int WC_W = idx_w(RD_WAIT);
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'((RD_WAIT > 1) ? RD_WAIT - 2 : 0);
  localparam logic [KI_W-1:0] KI_LAST = KI_W'(KEY_LEN - 1);

  ksa_state_t          r_state;
  logic [S_ADDR_W-1:0] r_i;
  logic [S_ADDR_W-1:0] r_j;
  logic [S_DATA_W-1:0] r_si;
  logic [S_DATA_W-1:0] r_sj;
  logic [KI_W-1:0]     r_kidx;
  logic [WC_W-1:0]     r_wcnt;
  logic [7:0]          w_kbyte;

  rc4_key_byte_sel #(.KEY_LEN(KEY_LEN), .KI_W(KI_W)) u_key_sel (
    .i_key  (secret_key),
    .i_kidx (r_kidx),
    .o_byte (w_kbyte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_kidx  <= '0;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_scramble) begin
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= ST_READ_I;
          end
        end
        ST_READ_I: begin
          r_wcnt  <= WC_LOAD;
          r_state <= (RD_WAIT > 1) ? ST_WAIT_I : ST_CAP_I;
        end
        ST_WAIT_I: begin
          if (r_wcnt == '0) r_state <= ST_CAP_I;
          else              r_wcnt  <= r_wcnt - 1'b1;
        end
        ST_CAP_I: begin
          r_si    <= ram_q;
          r_j     <= r_j + ram_q + w_kbyte;  // carries drop: j stays mod 256
          r_state <= ST_READ_J;
        end
        ST_READ_J: begin
          r_wcnt  <= WC_LOAD;
          r_state <= (RD_WAIT > 1) ? ST_WAIT_J : ST_CAP_J;
        end
        ST_WAIT_J: begin
          if (r_wcnt == '0) r_state <= ST_CAP_J;
          else              r_wcnt  <= r_wcnt - 1'b1;
        end
        ST_CAP_J: begin
          r_sj    <= ram_q;
          r_state <= ST_WR_I;
        end
        ST_WR_I: r_state <= ST_WR_J;
        ST_WR_J: begin
          if (r_i == '1) begin
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + 1'b1;
            r_kidx  <= (r_kidx == KI_LAST) ? '0 : r_kidx + 1'b1;
            r_state <= ST_READ_I;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so no input reaches them combinationally.
  always_comb begin
    ram_address_scramble = '0;
    ram_data_scramble    = '0;
    ram_wren_scramble    = 1'b0;
    done_scrambling      = 1'b0;
    case (r_state)
      ST_READ_I, ST_WAIT_I, ST_CAP_I: ram_address_scramble = r_i;
      ST_READ_J, ST_WAIT_J, ST_CAP_J: ram_address_scramble = r_j;
      ST_WR_I: begin
        ram_address_scramble = r_i;
        ram_data_scramble    = r_sj;
        ram_wren_scramble    = 1'b1;
      end
      ST_WR_J: begin
        ram_address_scramble = r_j;
        ram_data_scramble    = r_si;
        ram_wren_scramble    = 1'b1;
      end
      ST_DONE: done_scrambling = 1'b1;
      default: ;
    endcase
  end

endmodule
